// File: rtl/mmsa_pkg.sv
// Shared types and helpers for the mmsa_gen systolic matrix multiplier.
// Signedness is selected by the MMSA_SIGNED_EN macro (see mmsa_pe).
package mmsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_FEED  = 3'd3,
        ST_DRAIN = 3'd4
    } mmsa_state_e;

    function automatic int out_w(input int data_w, input int max_n);
        return 2 * data_w + $clog2(max_n);
    endfunction

    // Size codes beyond the array's largest dimension select MAX_N.
    function automatic logic [1:0] clamp_code(input logic [1:0] code, input int max_n);
        int lim;
        lim = $clog2(max_n) - 1;
        if (int'(code) > lim)
            return 2'(lim);
        return code;
    endfunction

endpackage

// File: rtl/mmsa_if.sv
// Load/request/result bundle for mmsa_gen; master drives, slave is the multiplier.
interface mmsa_if #(
    parameter int DATA_W  = 8,
    parameter int MAX_N   = 8,
    parameter int NUM_MAT = 4
);
    import mmsa_pkg::*;

    localparam int IDX_W = $clog2(NUM_MAT);
    localparam int OUT_W = out_w(DATA_W, MAX_N);

    logic              in_valid;
    logic [DATA_W-1:0] matrix;
    logic [1:0]        matrix_size;
    logic              in_valid2;
    logic [IDX_W-1:0]  i_mat_idx;
    logic [IDX_W-1:0]  w_mat_idx;
    logic              out_valid;
    logic [OUT_W-1:0]  out_value;

    modport master (
        output in_valid, matrix, matrix_size, in_valid2, i_mat_idx, w_mat_idx,
        input  out_valid, out_value
    );

    modport slave (
        input  in_valid, matrix, matrix_size, in_valid2, i_mat_idx, w_mat_idx,
        output out_valid, out_value
    );

endinterface

// File: rtl/mmsa_gen_pe.sv
// One output-stationary processing element: registered operand pass-through plus MAC.
// MMSA_SIGNED_EN selects sign extension of operands; otherwise zero extension.
module mmsa_pe
    import mmsa_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OUT_W  = out_w(DATA_W, 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [OUT_W-1:0]  acc
);

    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] b_ext;
    logic [OUT_W-1:0] prod;

`ifdef MMSA_SIGNED_EN
    assign a_ext = {{(OUT_W-DATA_W){a_in[DATA_W-1]}}, a_in};
    assign b_ext = {{(OUT_W-DATA_W){b_in[DATA_W-1]}}, b_in};
`else
    assign a_ext = {{(OUT_W-DATA_W){1'b0}}, a_in};
    assign b_ext = {{(OUT_W-DATA_W){1'b0}}, b_in};
`endif

    // Low OUT_W bits of the product are correct for both signed and unsigned operands.
    assign prod = a_ext * b_ext;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + prod;
        end
    end

endmodule

// File: rtl/mmsa_gen.sv
// mmsa_gen: matrix storage, skew lines, FSM and output mux around a MAX_N x MAX_N PE array.
// Operand signedness follows MMSA_SIGNED_EN (handled inside mmsa_pe).
//   IDLE  | after reset, storage zero; load or request accepted
//   LOAD  | streaming 2*NUM_MAT*N*N words into storage
//   READY | storage valid; load or request accepted
//   FEED  | skewed operands flowing through the array
//   DRAIN | emitting C row-major, one word per cycle
module mmsa_gen
    import mmsa_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MAX_N   = 8,
    parameter int NUM_MAT = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    mmsa_if.slave bus
);

    localparam int OUT_W = out_w(DATA_W, MAX_N);
    localparam int IDX_W = $clog2(NUM_MAT);
    localparam int RC_W  = $clog2(MAX_N);
    localparam int CNT_W = $clog2(2 * NUM_MAT * MAX_N * MAX_N);
    localparam int TMR_W = $clog2(MAX_N * MAX_N + 3 * MAX_N);

    mmsa_state_e       st;
    logic [1:0]        code_q;
    logic [CNT_W-1:0]  wcnt;
    logic [TMR_W-1:0]  tmr;
    logic [IDX_W-1:0]  i_sel;
    logic [IDX_W-1:0]  w_sel;

    logic [DATA_W-1:0] i_mem [NUM_MAT][MAX_N][MAX_N];
    logic [DATA_W-1:0] w_mem [NUM_MAT][MAX_N][MAX_N];

    logic [DATA_W-1:0] a_raw [MAX_N];
    logic [DATA_W-1:0] b_raw [MAX_N];
    logic [DATA_W-1:0] a_skw [MAX_N];
    logic [DATA_W-1:0] b_skw [MAX_N];
    logic [DATA_W-1:0] a_pe  [MAX_N][MAX_N-1];
    logic [DATA_W-1:0] b_pe  [MAX_N-1][MAX_N];
    logic [DATA_W-1:0] unused_a_edge [MAX_N];
    logic [DATA_W-1:0] unused_b_edge [MAX_N];
    logic [OUT_W-1:0]  acc   [MAX_N][MAX_N];

    int                lg_cur;
    int                n_cur;
    logic              idle_like;
    logic              load_we;
    logic              start;
    logic              last_word;
    logic [RC_W-1:0]   wr_row;
    logic [RC_W-1:0]   wr_col;
    logic [IDX_W-1:0]  wr_mat;
    logic              wr_set;
    logic [RC_W-1:0]   drain_row;
    logic [RC_W-1:0]   drain_col;
    logic              out_valid_q;
    logic [OUT_W-1:0]  out_value_q;

    assign lg_cur    = int'(code_q) + 1;
    assign n_cur     = 1 << lg_cur;
    assign idle_like = (st == ST_IDLE) || (st == ST_READY);
    assign load_we   = bus.in_valid && (idle_like || st == ST_LOAD);
    assign start     = idle_like && !bus.in_valid && bus.in_valid2;
    assign last_word = (int'(wcnt) == ((2 * NUM_MAT) << (2 * lg_cur)) - 1);

    // Word address: I matrices first, then W; row-major inside each N x N block.
    always_comb begin
        int w;
        w      = int'(wcnt);
        wr_col = RC_W'(w & (n_cur - 1));
        wr_row = RC_W'((w >> lg_cur) & (n_cur - 1));
        wr_mat = IDX_W'(w >> (2 * lg_cur));
        wr_set = ((w >> (2 * lg_cur)) & NUM_MAT) != 0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st     <= ST_IDLE;
            code_q <= '0;
            wcnt   <= '0;
            tmr    <= '0;
            i_sel  <= '0;
            w_sel  <= '0;
        end else begin
            case (st)
                ST_IDLE, ST_READY: begin
                    if (bus.in_valid) begin
                        code_q <= clamp_code(bus.matrix_size, MAX_N);
                        wcnt   <= CNT_W'(1);
                        st     <= ST_LOAD;
                    end else if (bus.in_valid2) begin
                        i_sel <= bus.i_mat_idx;
                        w_sel <= bus.w_mat_idx;
                        tmr   <= TMR_W'(3 * n_cur - 2);
                        st    <= ST_FEED;
                    end
                end
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        if (last_word) begin
                            wcnt <= '0;
                            st   <= ST_READY;
                        end else begin
                            wcnt <= wcnt + CNT_W'(1);
                        end
                    end
                end
                ST_FEED: begin
                    if (tmr == '0) begin
                        tmr <= TMR_W'(n_cur * n_cur - 1);
                        st  <= ST_DRAIN;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (tmr == '0)
                        st <= ST_READY;
                    else
                        tmr <= tmr - TMR_W'(1);
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int m = 0; m < NUM_MAT; m++)
                for (int r = 0; r < MAX_N; r++)
                    for (int c = 0; c < MAX_N; c++) begin
                        i_mem[m][r][c] <= '0;
                        w_mem[m][r][c] <= '0;
                    end
        end else if (load_we) begin
            if (wr_set)
                w_mem[wr_mat][wr_row][wr_col] <= bus.matrix;
            else
                i_mem[wr_mat][wr_row][wr_col] <= bus.matrix;
        end
    end

    // Unskewed edge operands: step k presents column k of I and row k of W.
    always_comb begin
        int k;
        k = 3 * n_cur - 2 - int'(tmr);
        for (int r = 0; r < MAX_N; r++) begin
            a_raw[RC_W'(r)] = '0;
            b_raw[RC_W'(r)] = '0;
            if (st == ST_FEED && k < n_cur && r < n_cur) begin
                a_raw[RC_W'(r)] = i_mem[i_sel][RC_W'(r)][RC_W'(k)];
                b_raw[RC_W'(r)] = w_mem[w_sel][RC_W'(k)][RC_W'(r)];
            end
        end
    end

    for (genvar r = 0; r < MAX_N; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign a_skw[r] = a_raw[r];
            assign b_skw[r] = b_raw[r];
        end else begin : g_dly
            logic [r*DATA_W-1:0]     a_sr;
            logic [r*DATA_W-1:0]     b_sr;
            logic [(r+1)*DATA_W-1:0] a_nxt;
            logic [(r+1)*DATA_W-1:0] b_nxt;

            assign a_nxt = {a_sr, a_raw[r]};
            assign b_nxt = {b_sr, b_raw[r]};

            always_ff @(posedge clk) begin
                if (!rst_n || start) begin
                    a_sr <= '0;
                    b_sr <= '0;
                end else begin
                    a_sr <= a_nxt[r*DATA_W-1:0];
                    b_sr <= b_nxt[r*DATA_W-1:0];
                end
            end

            assign a_skw[r] = a_nxt[(r+1)*DATA_W-1 -: DATA_W];
            assign b_skw[r] = b_nxt[(r+1)*DATA_W-1 -: DATA_W];
        end
    end

    for (genvar r = 0; r < MAX_N; r++) begin : g_row
        for (genvar c = 0; c < MAX_N; c++) begin : g_col
            logic [DATA_W-1:0] a_i;
            logic [DATA_W-1:0] b_i;
            logic [DATA_W-1:0] a_o;
            logic [DATA_W-1:0] b_o;

            if (c == 0) begin : g_al
                assign a_i = a_skw[r];
            end else begin : g_ai
                assign a_i = a_pe[r][c-1];
            end
            if (r == 0) begin : g_bt
                assign b_i = b_skw[c];
            end else begin : g_bi
                assign b_i = b_pe[r-1][c];
            end
            if (c < MAX_N - 1) begin : g_ao
                assign a_pe[r][c] = a_o;
            end else begin : g_ae
                assign unused_a_edge[r] = a_o;
            end
            if (r < MAX_N - 1) begin : g_bo
                assign b_pe[r][c] = b_o;
            end else begin : g_be
                assign unused_b_edge[c] = b_o;
            end

            mmsa_pe #(
                .DATA_W (DATA_W),
                .OUT_W  (OUT_W)
            ) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (start),
                .a_in  (a_i),
                .b_in  (b_i),
                .a_out (a_o),
                .b_out (b_o),
                .acc   (acc[r][c])
            );
        end
    end

    always_comb begin
        int d;
        d         = n_cur * n_cur - 1 - int'(tmr);
        drain_row = RC_W'(d >> lg_cur);
        drain_col = RC_W'(d & (n_cur - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_value_q <= '0;
        end else if (st == ST_DRAIN) begin
            out_valid_q <= 1'b1;
            out_value_q <= acc[drain_row][drain_col];
        end else begin
            out_valid_q <= 1'b0;
            out_value_q <= '0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_value = out_value_q;

endmodule

// File: tb/tb_mmsa_gen.sv
// Directed bench for mmsa_gen; expected values follow MMSA_SIGNED_EN when it is defined.
module tb_mmsa_gen;
    import mmsa_pkg::*;

    localparam int OUT_W = out_w(8, 8);
`ifdef MMSA_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mmsa_if #(.DATA_W(8), .MAX_N(8), .NUM_MAT(4)) intf ();

    mmsa_gen #(.DATA_W(8), .MAX_N(8), .NUM_MAT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]       tb_i  [4][64];
    logic [7:0]       tb_w  [4][64];
    logic [OUT_W-1:0] exp_v [64];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ov"}, 32'(intf.out_valid), 32'd0);
        chk({tag, "_val"}, 32'(intf.out_value), 32'd0);
    endtask

    task automatic fill_const(input int m, input logic [7:0] iv, input logic [7:0] wv);
        for (int e = 0; e < 64; e++) begin
            tb_i[m][e] = iv;
            tb_w[m][e] = wv;
        end
    endtask

    task automatic set_exp(input logic [OUT_W-1:0] v);
        for (int e = 0; e < 64; e++) exp_v[e] = v;
    endtask

    task automatic set_exp4(input int v0, input int v1, input int v2, input int v3);
        exp_v[0] = OUT_W'(v0);
        exp_v[1] = OUT_W'(v1);
        exp_v[2] = OUT_W'(v2);
        exp_v[3] = OUT_W'(v3);
    endtask

    task automatic load(input logic [1:0] code, input int n, input bit req_too, input int gap_at);
        int idx;
        idx = 0;
        for (int s = 0; s < 2; s++)
            for (int m = 0; m < 4; m++)
                for (int e = 0; e < n * n; e++) begin
                    if (idx == gap_at) begin
                        intf.in_valid  = 1'b0;
                        intf.in_valid2 = 1'b0;
                        repeat (3) begin
                            tick();
                            chk("gap_ov", 32'(intf.out_valid), 32'd0);
                        end
                    end
                    intf.in_valid    = 1'b1;
                    intf.matrix_size = (idx == 0) ? code : ~code;
                    intf.matrix      = (s == 0) ? tb_i[m][e] : tb_w[m][e];
                    intf.in_valid2   = req_too && (idx == 0);
                    intf.i_mat_idx   = 2'd0;
                    intf.w_mat_idx   = 2'd0;
                    tick();
                    chk("load_ov", 32'(intf.out_valid), 32'd0);
                    idx++;
                end
        intf.in_valid  = 1'b0;
        intf.in_valid2 = 1'b0;
    endtask

    task automatic req(input int im, input int wm, input int n, input string tag, input int busy_at);
        intf.i_mat_idx = 2'(im);
        intf.w_mat_idx = 2'(wm);
        intf.in_valid2 = 1'b1;
        tick();
        intf.in_valid2 = 1'b0;
        for (int k = 1; k < 3 * n + n * n; k++) begin
            if (k - 1 == busy_at) begin
                intf.in_valid2 = 1'b1;
                intf.i_mat_idx = 2'd1;
                intf.w_mat_idx = 2'd1;
                intf.in_valid  = 1'b1;
                intf.matrix    = 8'h5a;
            end
            tick();
            intf.in_valid2 = 1'b0;
            intf.in_valid  = 1'b0;
            if (k >= 3 * n) begin
                chk({tag, "_ov"}, 32'(intf.out_valid), 32'd1);
                chk({tag, "_val"}, 32'(intf.out_value), 32'(exp_v[k - 3 * n]));
            end else begin
                chk({tag, "_pre_ov"}, 32'(intf.out_valid), 32'd0);
                chk({tag, "_pre_val"}, 32'(intf.out_value), 32'd0);
            end
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        intf.in_valid    = 1'b0;
        intf.matrix      = '0;
        intf.matrix_size = '0;
        intf.in_valid2   = 1'b0;
        intf.i_mat_idx   = '0;
        intf.w_mat_idx   = '0;
        repeat (3) tick();
        chk_idle("rst");
        rst_n = 1'b1;
        tick();
        chk_idle("idle");

        // Request straight out of reset: zero storage, N = 2.
        set_exp('0);
        req(0, 0, 2, "zero_idle", -1);
        tick();
        chk_idle("zero_end");

        // N = 2 load with a pause and a colliding request on the first word.
        for (int m = 0; m < 4; m++) fill_const(m, 8'd3, 8'd3);
        tb_i[0][0] = 8'd1; tb_i[0][1] = 8'd2; tb_i[0][2] = 8'd3; tb_i[0][3] = 8'd4;
        tb_w[0][0] = 8'd5; tb_w[0][1] = 8'd6; tb_w[0][2] = 8'd7; tb_w[0][3] = 8'd8;
        tb_i[2][0] = 8'd1; tb_i[2][1] = 8'd0; tb_i[2][2] = 8'd0; tb_i[2][3] = 8'd1;
        tb_w[3][0] = 8'd9; tb_w[3][1] = 8'd8; tb_w[3][2] = 8'd7; tb_w[3][3] = 8'd6;
        load(2'd0, 2, 1'b1, 10);

        set_exp4(19, 22, 43, 50);
        req(0, 0, 2, "mm2", -1);
        set_exp4(9, 8, 7, 6);
        req(2, 3, 2, "idx", -1);
        set_exp4(19, 22, 43, 50);
        req(0, 0, 2, "b2b", -1);
        req(0, 0, 2, "busy", 6);
        req(0, 0, 2, "after_busy", -1);
        tick();
        chk_idle("n2_end");

        // N = 8 via clamped code 3.
        fill_const(0, 8'h80, 8'h80);
        fill_const(1, 8'hff, 8'h01);
        fill_const(2, 8'hff, 8'hff);
        fill_const(3, 8'h00, 8'h00);
        load(2'd3, 8, 1'b0, -1);

        set_exp(OUT_W'(131072));
        req(0, 0, 8, "m80", -1);
        set_exp(SGN ? OUT_W'(524280) : OUT_W'(2040));
        req(1, 1, 8, "neg", -1);
        set_exp(SGN ? OUT_W'(8) : OUT_W'(520200));
        req(2, 2, 8, "max", -1);

        // Reset while word 5 of a burst is on the output.
        intf.i_mat_idx = 2'd0;
        intf.w_mat_idx = 2'd0;
        intf.in_valid2 = 1'b1;
        tick();
        intf.in_valid2 = 1'b0;
        repeat (3 * 8 + 5) tick();
        chk("rstd_w5_ov", 32'(intf.out_valid), 32'd1);
        chk("rstd_w5_val", 32'(intf.out_value), 32'd131072);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_idle("rstd_next");
        tick();
        chk_idle("rstd_idle");
        set_exp('0);
        req(0, 0, 2, "post_rst", -1);
        tick();
        chk_idle("final");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mmsa_gen.md
# mmsa_gen

Parametrised successor to the MMSA matrix multiplier. Loads NUM_MAT input matrices and NUM_MAT weight matrices of size N×N into internal storage. On each request it computes one product C = I[i]×W[w] on a MAX_N×MAX_N output-stationary systolic array. Inputs and outputs are word-parallel, and the block accepts repeated requests without reloading.

## Interface
- DATA_W, 8, operand width in bits
- MAX_N, 8, largest supported matrix dimension; power of two, ≥2
- NUM_MAT, 4, matrices per set; power of two, ≥2
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  load strobe; one operand word per cycle
- matrix  in  DATA_W  operand word
- matrix_size  in  2  size code, N = 2 << code; sampled on the first in_valid cycle; codes above log2(MAX_N)-1 are clamped to MAX_N
- in_valid2  in  1  single-cycle compute request
- i_mat_idx  in  $clog2(NUM_MAT)  input-matrix index; sampled with in_valid2
- w_mat_idx  in  $clog2(NUM_MAT)  weight-matrix index; sampled with in_valid2
- out_valid  out  1  result word valid
- out_value  out  OUT_W  result element; OUT_W = 2*DATA_W + $clog2(MAX_N)

## Operation
- States are IDLE, LOAD, READY, FEED and DRAIN.
- **IDLE**
  - in_valid moves the block to LOAD and captures N.
  - in_valid2 is honoured. Storage is all-zero after reset, so the result is all zeros.
- **LOAD**
  - Accepts exactly 2·NUM_MAT·N² words, row-major: I[0]..I[NUM_MAT-1], then W[0]..W[NUM_MAT-1].
  - A word counter steps through the words. On the last word the block moves to READY.
  - in_valid dropping early keeps the block in LOAD. The counter holds and the load resumes when in_valid returns.
- **READY**
  - in_valid starts a new LOAD, overwrites all matrices and recaptures N.
  - in_valid2 captures the indices, clears all PE accumulators and moves to FEED.
- **FEED**
  - Row r of I enters the left edge of array row r, delayed by r cycles.
  - Column c of W enters the top edge of array column c, delayed by c cycles.
  - Operands at row/column positions ≥N are driven as zero.
  - Each PE performs acc += a·b, then forwards a to the right and b downward, each through one register.
- **DRAIN**
  - Emits C[r][c] for r,c < N, row-major, on N² consecutive cycles.
  - Then returns to READY.
- in_valid2 and in_valid are ignored in FEED and DRAIN. They must not corrupt the result or the storage.
- Arithmetic: operands are extended to OUT_W and accumulation is at OUT_W. No overflow is possible for N ≤ MAX_N.
- Signedness is set by the configuration macro (see Configuration).

## Timing
- Reset values:
  - out_valid = 0, out_value = 0.
  - State = IDLE; all storage, counters and accumulators = 0.
- out_value = 0 whenever out_valid = 0.
- If in_valid2 is sampled at cycle t, out_valid is high on cycles t+3N .. t+3N+N²-1.
- A new in_valid2 is accepted from cycle t+3N+N² onward.
- Back-to-back requests give a gap of 3N cycles of out_valid = 0 between bursts.
- A load is complete 2·NUM_MAT·N² accepting cycles after it starts. in_valid2 is legal on the cycle after the last word.
- Reset during any state: the next cycle is IDLE with out_valid = 0, and the in-flight burst is truncated.
- in_valid and in_valid2 asserted together in READY: in_valid wins and the request is dropped.

## Configuration
- **MMSA_SIGNED_EN defined**
  - Operands are two's complement and are sign-extended to OUT_W.
  - out_value is a two's-complement OUT_W result.
- **MMSA_SIGNED_EN undefined**
  - Operands are unsigned and zero-extended.
  - out_value is unsigned.

## Structure
- Shared package mmsa_pkg holds:
  - the state enum (IDLE/LOAD/READY/FEED/DRAIN);
  - a function `out_w(data_w, max_n)`;
  - the size-code clamp function.
- Sub-module mmsa_pe: one processing element. It has operand in/out registers, an OUT_W accumulator, a synchronous clear and the signedness handling under MMSA_SIGNED_EN.
- The top level instantiates MAX_N² copies of mmsa_pe through generate loops.
- The top level also holds the storage array, the skew delay lines, the FSM and the output mux.

## Test plan
- **Unsigned, N=2:**
  - Stimulus: code 0; I[0] = {1,2,3,4}, W[0] = {5,6,7,8}; request (0,0).
  - Response: out_valid on t+6..t+9 with values 19, 22, 43, 50.
- **Index selection:**
  - Stimulus: N=2, I[2] = identity, W[3] = {9,8,7,6}; request (2,3).
  - Response: 9, 8, 7, 6. A back-to-back request (0,0) then gives 19, 22, 43, 50 after a 6-cycle gap.
- **Max magnitude, unsigned, N=8:**
  - Stimulus: all words 255; any request.
  - Response: 64 words of 520200, starting at t+24.
- **Signed (MMSA_SIGNED_EN), N=8:**
  - Stimulus: all words 0x80.
  - Response: 64 words of 131072. With I = -1 everywhere and W = 1, the response is 64 words of -8.
- **Busy-state request:**
  - Stimulus: in_valid2 with indices (1,1) during DRAIN.
  - Response: ignored; the burst is unchanged and the block returns to READY.
- **Reset mid-DRAIN:**
  - Stimulus: rst_n low for one cycle at output word 5.
  - Response: out_valid = 0 and out_value = 0 next cycle. A subsequent request without a reload outputs all zeros.
